obstacle_scheduler: RTL and testbench

OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

---
 rtl/obstacle_pkg.sv | 35 +++
 rtl/lfsr8.sv | 15 +
 rtl/obstacle_scheduler.sv | 129 ++++++++++++
 tb/tb_obstacle_scheduler.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_pkg.sv
// Shared codes for the obstacle scheduler: game-state codes, scheduler FSM states,
// lane location codes and the LFSR seed/taps.
package obstacle_pkg;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_RUN  = 4'd1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_GAMEOVER = 2'd2
    } sched_state_t;

    localparam int LOC_W = 3;
    localparam logic [LOC_W-1:0] LOC_LANE0 = 3'd0;
    localparam logic [LOC_W-1:0] LOC_LANE1 = 3'd1;
    localparam logic [LOC_W-1:0] LOC_LANE2 = 3'd2;
    localparam logic [LOC_W-1:0] LOC_LANE3 = 3'd3;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Feedback taps for x^8+x^6+x^5+x^4+1 in a left-shifting register.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [LOC_W-1:0] loc_from_lfsr(input logic [1:0] r);
        logic [LOC_W-1:0] loc;
        case (r)
            2'd0:    loc = LOC_LANE0;
            2'd1:    loc = LOC_LANE1;
            2'd2:    loc = LOC_LANE2;
            default: loc = LOC_LANE3;
        endcase
        return loc;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; advances every clock regardless of game state.
module lfsr8
    import obstacle_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    output logic [7:0] out
);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) out <= LFSR_SEED;
        else       out <= {out[6:0], ^(out & LFSR_TAPS)};
    end

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle slot scheduler: spawns obstacles into free slots on game ticks, counts
// cleared obstacles. Define SPEED_RAMP_EN to raise speed every 16 points.
module obstacle_scheduler
    import obstacle_pkg::*;
#(
    parameter int         NSLOT      = 4,
    parameter int         SPAWN_MIN  = 60,
    parameter logic [7:0] SPEED_INIT = 8'd1,
    parameter logic [7:0] SPEED_MAX  = 8'd8
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               tick,
    input  logic [3:0]         state,
    input  logic               collision,
    input  logic [NSLOT-1:0]   done,
    output logic [NSLOT-1:0]   busy,
    output logic [3*NSLOT-1:0] location,
    output logic [7:0]         speed,
    output logic [15:0]        score,
    output logic               game_over
);

    localparam int TW = $clog2(SPAWN_MIN + 64);
    localparam int CW = $clog2(NSLOT + 1);
    localparam logic [TW-1:0] TIMER_INIT  = TW'(SPAWN_MIN);
    localparam logic [7:0]    SPEED_START = (SPEED_INIT > SPEED_MAX) ? SPEED_MAX : SPEED_INIT;

    sched_state_t       fsm, fsm_n;
    logic [TW-1:0]      timer, timer_n;
    logic [7:0]         lfsr;
    logic [NSLOT-1:0]   busy_n, hit;
    logic [3*NSLOT-1:0] loc_n;
    logic [7:0]         speed_n;
    logic [15:0]        score_n;
    logic               go_n, found;
    logic [CW-1:0]      nhit;
    logic [16:0]        score_sum;

    lfsr8 u_lfsr (.CLK(CLK), .RESET(RESET), .out(lfsr));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fsm       <= S_IDLE;
            busy      <= '0;
            location  <= '0;
            speed     <= SPEED_INIT;
            score     <= '0;
            game_over <= 1'b0;
            timer     <= TIMER_INIT;
        end else begin
            fsm       <= fsm_n;
            busy      <= busy_n;
            location  <= loc_n;
            speed     <= speed_n;
            score     <= score_n;
            game_over <= go_n;
            timer     <= timer_n;
        end
    end

    always_comb begin
        fsm_n   = fsm;
        busy_n  = busy;
        loc_n   = location;
        speed_n = speed;
        score_n = score;
        go_n    = game_over;
        timer_n = timer;
        found   = 1'b0;
        hit     = done & busy;
        nhit    = '0;
        for (int i = 0; i < NSLOT; i++) nhit = nhit + CW'(hit[i]);
        score_sum = {1'b0, score} + 17'(nhit);

        case (fsm)
            S_IDLE: begin
                if (state == ST_RUN) begin
                    fsm_n   = S_RUN;
                    score_n = '0;
                    speed_n = SPEED_START;
                    timer_n = TIMER_INIT;
                    busy_n  = '0;
                end
            end
            S_RUN: begin
                if (collision) begin
                    fsm_n  = S_GAMEOVER;
                    busy_n = '0;
                    go_n   = 1'b1;
                end else if (state != ST_RUN) begin
                    fsm_n  = S_IDLE;
                    busy_n = '0;
                end else begin
                    busy_n  = busy & ~done;
                    score_n = score_sum[16] ? 16'hFFFF : score_sum[15:0];
`ifdef SPEED_RAMP_EN
                    if (score_n[15:4] != score[15:4] && speed < SPEED_MAX)
                        speed_n = speed + 8'd1;
`endif
                    // Free slots come from the registered busy, so a slot retiring
                    // this cycle cannot be refilled until the next one.
                    if (tick) begin
                        if (timer != '0) begin
                            timer_n = timer - TW'(1);
                        end else begin
                            for (int i = 0; i < NSLOT; i++) begin
                                if (!found && !busy[i]) begin
                                    found              = 1'b1;
                                    busy_n[i]          = 1'b1;
                                    loc_n[3*i +: 3]    = loc_from_lfsr(lfsr[1:0]);
                                    timer_n            = TIMER_INIT + TW'(lfsr[7:2]);
                                end
                            end
                        end
                    end
                end
            end
            S_GAMEOVER: begin
                if (state == ST_IDLE) begin
                    fsm_n = S_IDLE;
                    go_n  = 1'b0;
                end
            end
            default: fsm_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Randomized + directed bench for obstacle_scheduler against a behavioural model.
module tb_obstacle_scheduler;
    import obstacle_pkg::*;

`ifdef SPEED_RAMP_EN
    localparam logic [7:0] SPD16  = 8'd2;
    localparam logic [7:0] SPDEND = 8'd8;
    localparam bit         RAMP   = 1'b1;
`else
    localparam logic [7:0] SPD16  = 8'd1;
    localparam logic [7:0] SPDEND = 8'd1;
    localparam bit         RAMP   = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        tick = 1'b0;
    logic [3:0]  state = ST_IDLE;
    logic        collision = 1'b0;
    logic [3:0]  done = '0;
    logic [3:0]  busy;
    logic [11:0] location;
    logic [7:0]  speed;
    logic [15:0] score;
    logic        game_over;

    obstacle_scheduler dut (
        .CLK(CLK), .RESET(RESET), .tick(tick), .state(state), .collision(collision),
        .done(done), .busy(busy), .location(location), .speed(speed), .score(score),
        .game_over(game_over)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // behavioural model (mode: 0 idle, 1 run, 2 game over)
    int          mode_m;
    logic [3:0]  busy_m;
    logic [11:0] loc_m;
    int          speed_m, score_m, timer_m;
    logic [7:0]  lfsr_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [7:0] cur;
        logic [3:0] old;
        bit         placed;
        forever begin
            @(posedge CLK or posedge RESET);
            if (RESET) begin
                mode_m = 0; busy_m = '0; loc_m = '0; speed_m = 1; score_m = 0;
                timer_m = 60; lfsr_m = 8'hA5;
            end else begin
                cur = lfsr_m;
                lfsr_m = {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
                if (mode_m == 0) begin
                    if (state == ST_RUN) begin
                        mode_m = 1; score_m = 0; speed_m = 1; timer_m = 60; busy_m = '0;
                    end
                end else if (mode_m == 1) begin
                    if (collision) begin
                        mode_m = 2; busy_m = '0;
                    end else if (state != ST_RUN) begin
                        mode_m = 0; busy_m = '0;
                    end else begin
                        old = busy_m;
                        for (int i = 0; i < 4; i++) begin
                            if (done[i] && old[i]) begin
                                busy_m[i] = 1'b0;
                                if (score_m < 65535) begin
                                    score_m++;
                                    if (RAMP && score_m % 16 == 0 && speed_m < 8) speed_m++;
                                end
                            end
                        end
                        if (tick) begin
                            if (timer_m > 0) timer_m--;
                            else begin
                                placed = 0;
                                for (int i = 0; i < 4; i++) begin
                                    if (!placed && !old[i]) begin
                                        placed = 1;
                                        busy_m[i] = 1'b1;
                                        loc_m[3*i +: 3] = {1'b0, cur[1:0]};
                                        timer_m = 60 + int'(cur[7:2]);
                                    end
                                end
                            end
                        end
                    end
                end else if (state == ST_IDLE) begin
                    mode_m = 0;
                end
            end
        end
    end

    // every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge CLK);
            if (!RESET) begin
                chk("busy", 32'(busy), 32'(busy_m));
                chk("location", 32'(location), 32'(loc_m));
                chk("speed", 32'(speed), 32'(speed_m));
                chk("score", 32'(score), 32'(score_m));
                chk("game_over", 32'(game_over), 32'(mode_m == 2));
            end
        end
    end

    // called at a negedge; returns at the negedge after the edge that consumed the inputs
    task automatic step(input logic tk, input logic [3:0] dn, input logic col);
        tick = tk; done = dn; collision = col;
        @(negedge CLK);
        tick = 1'b0; done = '0; collision = 1'b0;
    endtask

    initial begin
        int  first, n;
        bit  seen16;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_location", 32'(location), 32'h0);
        chk("rst_speed", 32'(speed), 32'h1);
        chk("rst_score", 32'(score), 32'h0);
        chk("rst_game_over", 32'(game_over), 32'h0);

        // first spawn after 61 ticks
        state = ST_RUN;
        step(0, 4'b0, 0);
        chk("model_lfsr_a", 32'(lfsr_m), 32'h95);
        first = -1;
        for (int t = 1; t <= 70 && first < 0; t++) begin
            step(1, 4'b0, 0);
            if (busy[0]) first = t;
            repeat (3) step(0, 4'b0, 0);
        end
        chk("first_spawn_tick", 32'(first), 32'd61);

        // fill all slots, then let the timer run down to a pending spawn
        n = 0;
        while (busy != 4'hF && n < 2000) begin step(1, 4'b0, 0); step(0, 4'b0, 0); n++; end
        chk("all_busy", 32'(busy), 32'hF);
        repeat (130) begin step(1, 4'b0, 0); step(0, 4'b0, 0); end
        chk("full_hold", 32'(busy), 32'hF);
        chk("timer_pending", 32'(timer_m), 32'd0);
        step(0, 4'b0100, 0);
        chk("done2_busy", 32'(busy), 32'hB);
        chk("done2_score", 32'(score), 32'd1);
        step(1, 4'b0, 0);
        chk("respawn_slot2", 32'(busy), 32'hF);

        // two retirements in one cycle
        step(0, 4'b1010, 0);
        chk("done13_score", 32'(score), 32'd3);
        chk("done13_busy", 32'(busy), 32'h5);

        // collision coincides with a retirement and a spawning tick
        n = 0;
        while (timer_m != 0 && n < 200) begin step(1, 4'b0, 0); n++; end
        chk("pre_collide_timer", 32'(timer_m), 32'd0);
        step(1, 4'b0001, 1);
        chk("go_flag", 32'(game_over), 32'd1);
        chk("go_busy", 32'(busy), 32'h0);
        chk("go_score", 32'(score), 32'd3);
        step(0, 4'b0, 0);
        chk("go_hold", 32'(game_over), 32'd1);
        state = ST_IDLE;
        step(0, 4'b0, 0);
        chk("go_release", 32'(game_over), 32'd0);

        // long run with many retirements: speed ramp (or fixed speed)
        state = ST_RUN;
        step(0, 4'b0, 0);
        seen16 = 0; n = 0;
        while (score_m < 200 && n < 30000) begin
            step(1, busy_m & 4'($urandom), 0);
            if (!seen16 && score_m >= 16) begin
                seen16 = 1;
                chk("speed_at_16", 32'(speed), 32'(SPD16));
            end
            n++;
        end
        chk("score_reached_200", 32'(score >= 16'd200), 32'd1);
        chk("speed_final", 32'(speed), 32'(SPDEND));

        // random traffic
        for (int c = 0; c < 12000; c++) begin
            if ($urandom_range(499) == 0 || (mode_m == 2 && $urandom_range(49) == 0)) begin
                case ($urandom_range(3))
                    0:       state = ST_IDLE;
                    1, 2:    state = ST_RUN;
                    default: state = 4'd9;
                endcase
            end
            step($urandom_range(3) != 0,
                 ($urandom_range(3) == 0) ? 4'($urandom) : 4'b0,
                 $urandom_range(1499) == 0);
        end

        // asynchronous reset in the middle of a run
        state = ST_IDLE;
        repeat (2) step(0, 4'b0, 0);
        state = ST_RUN;
        n = 0;
        while (busy == 4'h0 && n < 400) begin step(1, 4'b0, 0); n++; end
        step(0, busy, 0);
        chk("pre_reset_score", 32'(score != 0), 32'd1);
        #2 RESET = 1'b1;
        #1;
        chk("async_busy", 32'(busy), 32'h0);
        chk("async_score", 32'(score), 32'h0);
        chk("async_game_over", 32'(game_over), 32'h0);
        @(negedge CLK);
        RESET = 1'b0;
        repeat (3) step(0, 4'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
